// File: rtl/lane_deskew_pkg.sv
// Shared types and constants for the lane deskew/merge receive path.
package lane_deskew_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StAligned,
        StError
    } state_e;

    localparam logic [7:0] SyncSymDefault = 8'hF0;

    function automatic int unsigned depth_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/lane_fifo.sv
// Single-clock per-lane FIFO with flush; a push on a full FIFO is dropped unless a pop
// happens in the same cycle.
module lane_fifo
    import lane_deskew_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [depth_w(DEPTH):0]  count
);

    localparam int unsigned DepthW = depth_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DepthW-1:0] wr_ptr_q, rd_ptr_q;
    logic [DepthW:0]   count_q;
    logic              do_push, do_pop;

    assign full    = (count_q == (DepthW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/lane_deskew_merge.sv
// Receive-side lane deskew: align each enabled lane on a sync marker, buffer per lane,
// and release one merged word per cycle once every enabled lane has a byte ready.
module lane_deskew_merge
    import lane_deskew_pkg::*;
#(
    parameter int unsigned       NUM_LANES  = 2,
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       FIFO_DEPTH = 8,
    parameter int unsigned       MAX_SKEW   = 6,
    parameter logic [DATA_W-1:0] SYNC_SYM   = DATA_W'(SyncSymDefault)
) (
    input  logic                          fsm_clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [NUM_LANES-1:0]          lane_mask,
    input  logic [NUM_LANES*DATA_W-1:0]   lane_rx_data,
    input  logic [NUM_LANES-1:0]          lane_rx_valid,
    output logic [NUM_LANES*DATA_W-1:0]   data_out,
    output logic                          data_valid,
    output logic                          deskew_done,
    output logic                          skew_error
);

    localparam int unsigned DepthW = depth_w(FIFO_DEPTH);
    localparam int unsigned SkewW  = $clog2(MAX_SKEW + 2);

    state_e                        state_q, state_d;
    logic [NUM_LANES-1:0]          mask_q, mask_d, seen_q, seen_d;
    logic [SkewW-1:0]              cnt_q, cnt_d;
    logic [NUM_LANES-1:0]          marker, push, pop_lane, overflow, full, empty;
    logic                          pop_all;
    logic [NUM_LANES*DATA_W-1:0]   rd_data, merged;
    // Fill levels are kept on the FIFO interface for debug visibility only.
    logic [DepthW:0]               count_unused [NUM_LANES];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk   (fsm_clk),
            .rst_n (rst),
            .flush (!enable),
            .push  (push[i]),
            .pop   (pop_lane[i]),
            .wdata (lane_rx_data[i*DATA_W +: DATA_W]),
            .rdata (rd_data[i*DATA_W +: DATA_W]),
            .full  (full[i]),
            .empty (empty[i]),
            .count (count_unused[i])
        );
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        seen_d  = seen_q;
        cnt_d   = cnt_q;
        push    = '0;
        marker  = '0;
        merged  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            marker[i] = mask_q[i] && lane_rx_valid[i] &&
                        (lane_rx_data[i*DATA_W +: DATA_W] == SYNC_SYM);
        end
        pop_all  = (state_q == StAligned) && ((mask_q & ~empty) == mask_q);
        pop_lane = pop_all ? mask_q : '0;

        unique case (state_q)
            StIdle: begin
                if (enable && (lane_mask != '0)) begin
                    mask_d  = lane_mask;
                    state_d = StSearch;
                end
            end
            StSearch: begin
                // Markers are consumed, never stored; only already-seen lanes buffer data.
                push   = seen_q & lane_rx_valid;
                seen_d = seen_q | marker;
                if (seen_d == mask_q) begin
                    state_d = StAligned;
                end else if (cnt_q == SkewW'(MAX_SKEW)) begin
                    state_d = StError;
                end else if (seen_d != '0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAligned: push = mask_q & lane_rx_valid;
            StError: ;
        endcase

        overflow = push & full & ~pop_lane;
        if (overflow != '0) state_d = StError;

        if (!enable) begin
            state_d = StIdle;
            seen_d  = '0;
            cnt_d   = '0;
        end

        for (int i = 0; i < NUM_LANES; i++) begin
            if (pop_lane[i]) merged[i*DATA_W +: DATA_W] = rd_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge fsm_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            seen_q      <= '0;
            cnt_q       <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            deskew_done <= 1'b0;
            skew_error  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            seen_q      <= seen_d;
            cnt_q       <= cnt_d;
            data_out    <= enable ? merged : '0;
            data_valid  <= enable && pop_all;
            deskew_done <= (state_d == StAligned);
            skew_error  <= (state_d == StError);
        end
    end

endmodule
